loopback_fifo: RTL and testbench
================================

# loopback_fifo

Parametrised elastic buffer between the UART receiver (`we`/`full` write side) and transmitter (`re`/`empty` read side), the next-generation buffer for the echo loopback. Beyond plain FIFO storage it adds:
- configurable width and depth;
- hold/drop operating modes and synchronous flush;
- overflow accounting;
- hysteretic RTS flow-control output toward the remote sender.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits.
- `DEPTH`, 16, entries; power of two, ≥2.
- `HIGH_MARK`, 12, level at or above which `rts_n` deasserts (goes high); must satisfy LOW_MARK < HIGH_MARK ≤ DEPTH.
- `LOW_MARK`, 4, level at or below which `rts_n` reasserts (goes low).

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  WIDTH  write data.
- `we`  in  1  write request, one word per cycle.
- `full`  out  1  registered; no space.
- `dout`  out  WIDTH  read data, registered.
- `re`  in  1  read request.
- `empty`  out  1  registered; nothing readable (also forced by HOLD).
- `mode`  in  2  operating mode, see Operation.
- `flush`  in  1  single-cycle synchronous discard-all pulse.
- `clr_stats`  in  1  clears `overflow` and `drop_count`.
- `level`  out  $clog2(DEPTH+1)  current occupancy.
- `rts_n`  out  1  flow control to the remote sender; low = may send.
- `overflow`  out  1  sticky; set by any rejected write.
- `drop_count`  out  16  saturating count of rejected/discarded writes.

## Operation
- Modes (`loopback_pkg::mode_t`):
  - `MODE_ECHO` = 0: normal operation.
  - `MODE_HOLD` = 1: writes accepted; `empty` forced 1; `re` ignored.
  - `MODE_DROP` = 2: every `we` is discarded and counted; reads proceed.
  - 3: reserved; behaves as ECHO.
- Write accepted when `we && !full` and mode ≠ DROP. Storage location: `wr_ptr`, which then increments modulo DEPTH.
- Write rejected when `we && full` (mode ≠ DROP):
  - `overflow` ← 1;
  - `drop_count` +1.
  - Data is lost; stored contents are unchanged.
- Read accepted when `re && !empty_int` and mode ≠ HOLD.
  - `dout` ← mem[`rd_ptr`] at that edge.
  - `rd_ptr` increments modulo DEPTH.
  - `dout` holds its value otherwise.
- Simultaneous accepted read and write: `level` is unchanged.
  - A read while full frees a slot the next cycle. A write in that same cycle sees `full` = 1 and is rejected.
  - A write while empty is accepted; a read in that same cycle is ignored.
- `level` is tracked as a DEPTH+1-valued counter, not derived from pointer difference.
  - `full` = (level == DEPTH).
  - `empty_int` = (level == 0).
- `flush` has priority over all other activity in its cycle:
  - pointers and `level` ← 0;
  - a concurrent read or write is ignored and not counted;
  - `dout` is unchanged.
- `drop_count` saturates at 0xFFFF.
- `clr_stats` clears both statistics. A drop in the same cycle wins: result is `overflow` = 1, `drop_count` = 1.
- `rts_n` hysteresis, evaluated on next-state level:
  - set to 1 when next level ≥ HIGH_MARK;
  - cleared to 0 when next level ≤ LOW_MARK;
  - otherwise holds its value.

## Timing
- Reset values (asynchronous): `full`=0, `empty`=1, `dout`=0, `level`=0, `rts_n`=0, `overflow`=0, `drop_count`=0, both pointers 0.
- All outputs are registered; no combinational input→output paths.
- Write at edge k: `level`, `empty`, `full` and `rts_n` reflect it from cycle k+1.
- Read latency: word valid on `dout` one cycle after the edge sampling `re`. This is standard (non-FWFT) FIFO behaviour.
- Mode changes take effect at the edge where the new `mode` is sampled.
- Entering HOLD raises `empty` from the next cycle.
- Reset asserted mid-operation discards all contents immediately; statistics are cleared.

## Structure
- `loopback_pkg`: `mode_t` enum, `MODE_*` constants, and the `DROP_CNT_W` = 16 constant.
- One sub-module, `fifo_ram`: a WIDTH×DEPTH synchronous-write, registered-read array (inputs `we`, `waddr`, `wdata`, `re`, `raddr`; output `rdata`).
- Pointers, level, flags, mode gating and statistics live in `loopback_fifo`.

## Test plan
Bench configuration: WIDTH=8, DEPTH=4, HIGH_MARK=3, LOW_MARK=1.

1. Reset, then write 0x41, 0x42, then read twice → `dout` = 0x41 then 0x42, each one cycle after `re`; `empty` = 1 at the end; `level` sequence 1, 2, 1, 0.
2. Write 0x10..0x14 on consecutive cycles with no reads → `full` = 1 after the 4th write; 5th write rejected; `overflow` = 1; `drop_count` = 1; reads return 0x10..0x13.
3. Fill to 3 → `rts_n` = 1. Read to level 2 → `rts_n` stays 1. Read to level 1 → `rts_n` = 0.
4. With `mode` = HOLD and 2 words written → `empty` = 1 and `re` ignored. Return to ECHO → `empty` = 0; data reads in order.
5. With `mode` = DROP, 3 writes → `level` = 0; `drop_count` = 3. `clr_stats` → `drop_count` = 0; `overflow` = 0.
6. With level = 3, `flush` together with `we` (0x55) and `re` → `level` = 0; `empty` = 1; `drop_count` unchanged. Then assert `rst` while writing → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/loopback_pkg.sv
// Shared types and constants for the loopback elastic buffer.
package loopback_pkg;

  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    MODE_ECHO = 2'd0,
    MODE_HOLD = 2'd1,
    MODE_DROP = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage array: synchronous write, registered read port.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/loopback_fifo.sv
// Elastic buffer between UART RX and TX with hold/drop modes, flush,
// overflow statistics and hysteretic RTS flow control.
module loopback_fifo
  import loopback_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int HIGH_MARK = 12,
  parameter int LOW_MARK  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             din,
  input  logic                         we,
  output logic                         full,
  output logic [WIDTH-1:0]             dout,
  input  logic                         re,
  output logic                         empty,
  input  logic [1:0]                   mode,
  input  logic                         flush,
  input  logic                         clr_stats,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         rts_n,
  output logic                         overflow,
  output logic [DROP_CNT_W-1:0]        drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_HIGH = LW'(HIGH_MARK);
  localparam logic [LW-1:0] LVL_LOW  = LW'(LOW_MARK);

  mode_t                  mode_s;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   full_q, empty_q;
  logic                   rts_q, rts_d;
  logic                   ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0]  drop_q, drop_d;
  logic                   wr_ok, rd_ok, wr_rej, drop_evt;

  assign mode_s = mode_t'(mode);

  // Flush suppresses every request in its cycle, including statistics.
  always_comb begin
    wr_ok    = 1'b0;
    rd_ok    = 1'b0;
    wr_rej   = 1'b0;
    drop_evt = 1'b0;
    if (!flush) begin
      if (we) begin
        if (mode_s == MODE_DROP) begin
          drop_evt = 1'b1;
        end else if (full_q) begin
          wr_rej   = 1'b1;
          drop_evt = 1'b1;
        end else begin
          wr_ok = 1'b1;
        end
      end
      rd_ok = re && (level_q != '0) && (mode_s != MODE_HOLD);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    rts_d = rts_q;
    if (level_d >= LVL_HIGH)     rts_d = 1'b1;
    else if (level_d <= LVL_LOW) rts_d = 1'b0;

    // A drop coinciding with clr_stats survives as the first new event.
    ovf_d  = ovf_q | wr_rej;
    drop_d = drop_q;
    if (clr_stats) begin
      ovf_d  = wr_rej;
      drop_d = drop_evt ? DROP_CNT_W'(1) : '0;
    end else if (drop_evt && (drop_q != '1)) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      rts_q    <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == LVL_FULL);
      empty_q  <= (level_d == '0) || (mode_s == MODE_HOLD);
      rts_q    <= rts_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (rd_ok),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

  assign full       = full_q;
  assign empty      = empty_q;
  assign level      = level_q;
  assign rts_n      = rts_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_loopback_fifo.sv
// Randomised and directed checks of loopback_fifo against a queue-based model.
module tb_loopback_fifo;
  import loopback_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int HM = 3;
  localparam int LM = 1;
  localparam int LW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic          we, re, flush, clr_stats;
  logic [1:0]    mode;
  logic          full, empty, rts_n, overflow;
  logic [W-1:0]  dout;
  logic [LW-1:0] level;
  logic [15:0]   drop_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout;
  logic         m_ovf, m_rts;
  int           m_drop;
  logic [1:0]   m_mode;
  string        phase;

  always #5 clk = ~clk;

  loopback_fifo #(
    .WIDTH     (W),
    .DEPTH     (D),
    .HIGH_MARK (HM),
    .LOW_MARK  (LM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .we         (we),
    .full       (full),
    .dout       (dout),
    .re         (re),
    .empty      (empty),
    .mode       (mode),
    .flush      (flush),
    .clr_stats  (clr_stats),
    .level      (level),
    .rts_n      (rts_n),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_rts  = 1'b0;
    m_drop = 0;
    m_mode = 2'd0;
  endtask

  // Applies the behavioural rules to the inputs sampled at this edge.
  task automatic model_edge();
    bit do_rd, do_wr, rej, dropped;
    do_rd = 0; do_wr = 0; rej = 0; dropped = 0;
    m_mode = mode;
    if (flush) begin
      mq.delete();
    end else begin
      do_rd = re && (mq.size() > 0) && (mode != MODE_HOLD);
      if (we) begin
        if (mode == MODE_DROP)   dropped = 1;
        else if (mq.size() == D) begin rej = 1; dropped = 1; end
        else                     do_wr = 1;
      end
      if (do_rd) m_dout = mq.pop_front();
      if (do_wr) mq.push_back(din);
    end
    if (clr_stats) begin
      m_ovf  = rej;
      m_drop = dropped ? 1 : 0;
    end else begin
      if (rej) m_ovf = 1'b1;
      if (dropped && m_drop < 65535) m_drop++;
    end
    if (mq.size() >= HM)      m_rts = 1'b1;
    else if (mq.size() <= LM) m_rts = 1'b0;
  endtask

  task automatic check_all();
    check({phase, ".level"},      32'(level),      32'(mq.size()));
    check({phase, ".full"},       32'(full),       32'(mq.size() == D));
    check({phase, ".empty"},      32'(empty),      32'((mq.size() == 0) || (m_mode == MODE_HOLD)));
    check({phase, ".dout"},       32'(dout),       32'(m_dout));
    check({phase, ".rts_n"},      32'(rts_n),      32'(m_rts));
    check({phase, ".overflow"},   32'(overflow),   32'(m_ovf));
    check({phase, ".drop_count"}, 32'(drop_count), 32'(m_drop));
  endtask

  task automatic step(input logic w, input logic [W-1:0] d, input logic r,
                      input logic [1:0] md, input logic fl, input logic cs);
    @(negedge clk);
    we = w; din = d; re = r; mode = md; flush = fl; clr_stats = cs;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, MODE_ECHO, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; we = 0; re = 0; din = '0; mode = MODE_ECHO; flush = 0; clr_stats = 0;
    model_reset();
    phase = "reset";
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0;

    phase = "t1";
    step(1, 8'h41, 0, MODE_ECHO, 0, 0);
    step(1, 8'h42, 0, MODE_ECHO, 0, 0);
    check("t1.level2", 32'(level), 32'd2);
    step(0, '0, 1, MODE_ECHO, 0, 0);
    check("t1.dout0", 32'(dout), 32'h41);
    step(0, '0, 1, MODE_ECHO, 0, 0);
    check("t1.dout1", 32'(dout), 32'h42);
    check("t1.empty", 32'(empty), 32'd1);

    phase = "t2";
    for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 0, MODE_ECHO, 0, 0);
    check("t2.full", 32'(full), 32'd1);
    check("t2.drop", 32'(drop_count), 32'd1);
    check("t2.ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 1, MODE_ECHO, 0, 0);
      check("t2.rd", 32'(dout), 32'(8'h10 + i));
    end

    phase = "t3";
    for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, MODE_ECHO, 0, 0);
    check("t3.rts_hi", 32'(rts_n), 32'd1);
    step(0, '0, 1, MODE_ECHO, 0, 0);
    check("t3.rts_mid", 32'(rts_n), 32'd1);
    step(0, '0, 1, MODE_ECHO, 0, 0);
    check("t3.rts_lo", 32'(rts_n), 32'd0);
    step(0, '0, 1, MODE_ECHO, 0, 0);

    phase = "t4";
    step(1, 8'hA1, 0, MODE_HOLD, 0, 0);
    step(1, 8'hA2, 0, MODE_HOLD, 0, 0);
    step(0, '0, 1, MODE_HOLD, 0, 0);
    check("t4.hold_empty", 32'(empty), 32'd1);
    check("t4.hold_level", 32'(level), 32'd2);
    step(0, '0, 0, MODE_ECHO, 0, 0);
    check("t4.echo_empty", 32'(empty), 32'd0);
    step(0, '0, 1, MODE_ECHO, 0, 0);
    check("t4.rd0", 32'(dout), 32'hA1);
    step(0, '0, 1, MODE_ECHO, 0, 0);
    check("t4.rd1", 32'(dout), 32'hA2);

    phase = "t5";
    step(0, '0, 0, MODE_ECHO, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 8'(8'hD0 + i), 0, MODE_DROP, 0, 0);
    check("t5.level", 32'(level), 32'd0);
    check("t5.drop", 32'(drop_count), 32'd3);
    step(0, '0, 0, MODE_ECHO, 0, 1);
    check("t5.clr_drop", 32'(drop_count), 32'd0);
    check("t5.clr_ovf", 32'(overflow), 32'd0);

    phase = "t6";
    for (int i = 0; i < 3; i++) step(1, 8'(8'hE0 + i), 0, MODE_ECHO, 0, 0);
    step(1, 8'h55, 1, MODE_ECHO, 1, 0);
    check("t6.flush_level", 32'(level), 32'd0);
    check("t6.flush_empty", 32'(empty), 32'd1);
    check("t6.flush_drop", 32'(drop_count), 32'd0);
    step(1, 8'h61, 0, MODE_ECHO, 0, 0);
    step(1, 8'h62, 0, MODE_ECHO, 0, 0);
    @(negedge clk);
    we = 1; din = 8'h63; re = 0; rst = 1'b1;
    model_reset();
    #1 phase = "t6.rst";
    check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst = 1'b0; we = 0;

    phase = "rand";
    for (int i = 0; i < 2500; i++) begin
      int unsigned r;
      logic [1:0] md;
      r = $urandom_range(0, 9);
      md = (r < 7) ? MODE_ECHO : (r == 7) ? MODE_HOLD : (r == 8) ? MODE_DROP : MODE_RSVD;
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), md,
           1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 39) == 0));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
